aes_cipher_iterative: RTL and testbench

- AES-128 encryption datapath, directly downstream of keyexpansion.
- Consumes the 1408-bit expanded round-key bus (`out`) and `finish` from keyexpansion.
- Encrypts one 128-bit block iteratively at one round per clock and reports completion with a one-cycle `finish` pulse.
- Sits between key schedule and the top-level engine/IO wrapper.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sbox.sv | 14 +
 rtl/aes_cipher_iterative.sv | 110 +++++++++++
 tb/tb_aes_cipher_iterative.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the cipher datapath and key schedule.
// Holds round count, bus widths, the forward S-box table, GF(2^8) helpers and
// the round-key slice helper used to pick RK[i] out of the expanded key bus.
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned BlockW   = 128;
  localparam int unsigned KEYBUS_W = 128 * (NR + 1);

  typedef enum logic [0:0] {StIdle, StRun} cipher_st_e;

  // Forward S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 with a0 in the MSBs; coefficients 02 03 01 01 rotate per row.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // RK0 (the cipher key) sits in the MSBs of the expanded bus.
  function automatic logic [BlockW-1:0] rk_slice(input logic [KEYBUS_W-1:0] keys,
                                                  input logic [3:0] idx);
    return keys[KEYBUS_W - 1 - 128 * int'(idx) -: 128];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
// Ports: a_i - input byte; d_o - substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] d_o
);

  always_comb begin
    d_o = sbox(a_i);
  end

endmodule

// File: rtl/aes_cipher_iterative.sv
// Iterative AES-128 encryption core, one round per clock.
// Ports:
//   clk, rst         - clock (rising edge) and asynchronous active-low reset
//   start            - encrypt request, honoured only when idle with keys_valid high
//   keys_valid       - expanded key bus is ready
//   round_keys       - expanded schedule, RK0 in the MSBs
//   plaintext        - input block, byte 0 in the MSBs
//   ciphertext       - last completed result, held until the next completion
//   busy             - block in flight
//   finish           - one-cycle pulse when ciphertext updates
module aes_cipher_iterative
  import aes_pkg::*;
#(
  parameter int unsigned NR       = aes_pkg::NR,
  parameter int unsigned KEYBUS_W = 128 * (NR + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                keys_valid,
  input  logic [KEYBUS_W-1:0] round_keys,
  input  logic [127:0]        plaintext,
  output logic [127:0]        ciphertext,
  output logic                busy,
  output logic                finish
);

  cipher_st_e   st_q;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic [127:0] ciphertext_q;
  logic         busy_q;
  logic         finish_q;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(state_q[127 - 8 * i -: 8]),
      .d_o(sub_bytes[127 - 8 * i -: 8])
    );
  end

  // State byte k = 4*col + row; row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8 * (4 * c + r) -: 8] = sub_bytes[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
    end
  end

  // Final round skips MixColumns.
  always_comb begin
    round_out = ((round_q == 4'(NR)) ? shifted : mixed) ^ rk_slice(round_keys, round_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= StIdle;
      state_q      <= '0;
      round_q      <= '0;
      ciphertext_q <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (start && keys_valid) begin
            state_q <= plaintext ^ rk_slice(round_keys, 4'd0);
            round_q <= 4'd1;
            busy_q  <= 1'b1;
            st_q    <= StRun;
          end
        end
        StRun: begin
          state_q <= round_out;
          if (round_q == 4'(NR)) begin
            ciphertext_q <= round_out;
            finish_q     <= 1'b1;
            busy_q       <= 1'b0;
            round_q      <= '0;
            st_q         <= StIdle;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign ciphertext = ciphertext_q;
  assign busy       = busy_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_aes_cipher_iterative.sv
// Scoreboard bench for aes_cipher_iterative: the driver pushes expected
// ciphertext and finish cycle, a negedge monitor pops on every finish pulse.
module tb_aes_cipher_iterative;

  logic          clk;
  logic          rst;
  logic          start;
  logic          keys_valid;
  logic [1407:0] round_keys;
  logic [127:0]  plaintext;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          finish;

  aes_cipher_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .keys_valid(keys_valid),
    .round_keys(round_keys),
    .plaintext (plaintext),
    .ciphertext(ciphertext),
    .busy      (busy),
    .finish    (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    int unsigned  cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Independent reference for the key schedule: S-box from GF inverse + affine map.
  function automatic logic [7:0] m_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = m_xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = m_gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])} ^ {rc, 24'h0};
        rc = m_xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407 - 32 * i -: 32] = w[i];
    return r;
  endfunction

  localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtA  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtB  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [1407:0] keys_a, keys_b, keys_z;

  // Monitor: every finish pulse must match the oldest expected block and cycle.
  always @(negedge clk) begin
    if (rst && finish) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_finish", 128'(cyc), 128'hffff_ffff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ciphertext", ciphertext, e.ct);
        chk("finish_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Call at a negedge; accept edge is the next posedge, finish 10 edges later.
  task automatic issue(input logic [127:0] pt, input logic [1407:0] k, input logic [127:0] ct);
    exp_t e;
    round_keys = k;
    plaintext  = pt;
    keys_valid = 1'b1;
    start      = 1'b1;
    e.ct  = ct;
    e.cyc = cyc + 11;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy || finish) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("timeout", 128'(sb_q.size()), 128'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic ok;
    int   n;

    keys_a = expand(KeyA);
    keys_b = expand(KeyB);
    keys_z = expand(128'h0);

    rst        = 1'b1;
    start      = 1'b0;
    keys_valid = 1'b0;
    round_keys = '0;
    plaintext  = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_ciphertext", ciphertext, 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    chk("reset_finish", 128'(finish), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B with busy window
    issue(PtA, keys_a, CtA);
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("busy_window", 128'(ok), 128'h1);
    chk("busy_clear", 128'(busy), 128'h0);
    wait_done();

    // FIPS-197 App. C.1
    issue(PtB, keys_b, CtB);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start gated by keys_valid
    keys_valid = 1'b0;
    start      = 1'b1;
    plaintext  = PtA;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || finish) ok = 1'b0;
    end
    chk("gated_idle", 128'(ok), 128'h1);
    start = 1'b0;
    @(negedge clk);

    // start hammered while busy, plaintext scrambled after accept
    issue(PtA, keys_a, CtA);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      start     = k[0];
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();

    // back-to-back: second start on the finish cycle
    issue(PtA, keys_a, CtA);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!finish && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_finish_seen", 128'(finish), 128'h1);
    issue(PtB, keys_b, CtB);
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (ciphertext !== CtA || !busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("b2b_ct_held", 128'(ok), 128'h1);
    wait_done();

    // reset at round 5
    issue(PtA, keys_a, CtA);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sb_q.delete();
    chk("abort_ciphertext", ciphertext, 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_finish", 128'(finish), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(PtA, keys_a, CtA);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // all-zero key and block
    issue(128'h0, keys_z, CtZ);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

endmodule
